// File: rtl/issue_ctrl_pkg.sv
// Shared types for the dual-issue controller: FSM encodings, register index
// width and the source/destination match helper.
package issue_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ISSUE_RUN   = 2'd0,
    ISSUE_DRAIN = 2'd1,
    ISSUE_SOLO  = 2'd2,
    ISSUE_POST  = 2'd3
  } issue_state_e;

  // r0 is hardwired zero, so it never participates in a dependency.
  function automatic logic reg_hit(input reg_idx_t src, input reg_idx_t dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/issue_ctrl_load_scoreboard.sv
// Tracks destinations of recently issued loads and flags any source operand
// that would read a load result before it is available.
module issue_ctrl_load_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_flush,
  input  logic     i_shift,
  input  logic     i_push,
  input  reg_idx_t i_push_rd,
  input  reg_idx_t i_rj0,
  input  reg_idx_t i_rk0,
  input  reg_idx_t i_rj1,
  input  reg_idx_t i_rk1,
  output logic     o_busy_j0,
  output logic     o_busy_k0,
  output logic     o_busy_j1,
  output logic     o_busy_k1
);

  logic [LOAD_LAT-1:0]            r_vld;
  logic [LOAD_LAT-1:0][REG_W-1:0] r_rd;

  // A push only ever coincides with a shift, since loads issue only when
  // the downstream stage accepts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      r_rd  <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else if (i_shift) begin
      r_vld[0] <= i_push;
      r_rd[0]  <= i_push_rd;
      for (int i = 1; i < LOAD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rd[i]  <= r_rd[i-1];
      end
    end
  end

  always_comb begin
    o_busy_j0 = 1'b0;
    o_busy_k0 = 1'b0;
    o_busy_j1 = 1'b0;
    o_busy_k1 = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (r_vld[i]) begin
        if (reg_hit(i_rj0, r_rd[i])) o_busy_j0 = 1'b1;
        if (reg_hit(i_rk0, r_rd[i])) o_busy_k0 = 1'b1;
        if (reg_hit(i_rj1, r_rd[i])) o_busy_j1 = 1'b1;
        if (reg_hit(i_rk1, r_rd[i])) o_busy_k1 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler from the IQ head into REG_EX1: pairing rules, load
// scoreboard hazards, serialisation FSM and a saturating stall counter.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             flush,
  input  logic [1:0]       iq_valid,
  input  logic [REG_W-1:0] iq_rd0,
  input  logic [REG_W-1:0] iq_rj0,
  input  logic [REG_W-1:0] iq_rk0,
  input  logic [REG_W-1:0] iq_rd1,
  input  logic [REG_W-1:0] iq_rj1,
  input  logic [REG_W-1:0] iq_rk1,
  input  logic             iq_is_ALU_0,
  input  logic             iq_is_ALU_1,
  input  logic             iq_is_load_0,
  input  logic             iq_is_load_1,
  input  logic             iq_is_branch_0,
  input  logic             iq_serial_0,
  input  logic             iq_serial_1,
  input  logic             ex_allowin,
  input  logic             pipe_empty,
  output logic             issue_valid0,
  output logic             issue_valid1,
  output logic [1:0]       issue_num,
  output logic [CNT_W-1:0] stall_cycles
);

  issue_state_e     r_state;
  logic [CNT_W-1:0] r_stall;

  logic     w_busy_j0, w_busy_k0, w_busy_j1, w_busy_k1;
  logic     w_haz0, w_haz1;
  logic     w_slot0_ok;
  logic     w_issue0, w_issue1;
  logic     w_raw, w_waw, w_fu_ok;
  logic     w_push;
  reg_idx_t w_push_rd;
  logic     w_stall_evt;

  issue_ctrl_load_scoreboard #(
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .i_clk     (aclk),
    .i_rst     (areset),
    .i_flush   (flush),
    .i_shift   (ex_allowin),
    .i_push    (w_push),
    .i_push_rd (w_push_rd),
    .i_rj0     (iq_rj0),
    .i_rk0     (iq_rk0),
    .i_rj1     (iq_rj1),
    .i_rk1     (iq_rk1),
    .o_busy_j0 (w_busy_j0),
    .o_busy_k0 (w_busy_k0),
    .o_busy_j1 (w_busy_j1),
    .o_busy_k1 (w_busy_k1)
  );

  assign w_haz0 = w_busy_j0 | w_busy_k0;
  assign w_haz1 = w_busy_j1 | w_busy_k1;

  assign w_raw   = reg_hit(iq_rj1, iq_rd0) | reg_hit(iq_rk1, iq_rd0);
  assign w_waw   = reg_hit(iq_rd1, iq_rd0);
  assign w_fu_ok = (iq_is_ALU_0 | iq_is_ALU_1) & ~(iq_is_load_0 & iq_is_load_1);

  assign w_slot0_ok = ~areset & ~flush & ex_allowin & iq_valid[0] & ~w_haz0;

  // In SOLO the serialising instruction at the head is the one allowed out.
  always_comb begin
    w_issue0 = 1'b0;
    case (r_state)
      ISSUE_RUN:  w_issue0 = w_slot0_ok & ~iq_serial_0;
      ISSUE_SOLO: w_issue0 = w_slot0_ok;
      default:    w_issue0 = 1'b0;
    endcase
  end

  assign w_issue1 = w_issue0 & (r_state == ISSUE_RUN) & iq_valid[1]
                  & ~iq_serial_1 & ~iq_is_branch_0 & ~w_haz1
                  & ~w_raw & ~w_waw & w_fu_ok;

  // Loads never pair, so at most one destination enters per cycle.
  always_comb begin
    w_push    = 1'b0;
    w_push_rd = '0;
    if (w_issue0 && iq_is_load_0 && iq_rd0 != '0) begin
      w_push    = 1'b1;
      w_push_rd = iq_rd0;
    end else if (w_issue1 && iq_is_load_1 && iq_rd1 != '0) begin
      w_push    = 1'b1;
      w_push_rd = iq_rd1;
    end
  end

  assign issue_valid0 = w_issue0;
  assign issue_valid1 = w_issue1;
  assign issue_num    = {1'b0, w_issue0} + {1'b0, w_issue1};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ISSUE_RUN;
    end else if (flush) begin
      r_state <= ISSUE_RUN;
    end else begin
      case (r_state)
        ISSUE_RUN: begin
          if (iq_valid[0] && iq_serial_0 && ex_allowin) r_state <= ISSUE_DRAIN;
        end
        ISSUE_DRAIN: begin
          if (pipe_empty) r_state <= ISSUE_SOLO;
        end
        ISSUE_SOLO: begin
          if (w_issue0) r_state <= ISSUE_POST;
        end
        ISSUE_POST: begin
          if (pipe_empty) r_state <= ISSUE_RUN;
        end
        default: r_state <= ISSUE_RUN;
      endcase
    end
  end

  assign w_stall_evt = iq_valid[0] & ex_allowin & ~w_issue0 & ~flush;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_stall <= '0;
    end else if (w_stall_evt && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int CNT_W = 6;

  logic             aclk = 1'b0;
  logic             areset, flush;
  logic [1:0]       iq_valid;
  logic [4:0]       iq_rd0, iq_rj0, iq_rk0, iq_rd1, iq_rj1, iq_rk1;
  logic             iq_is_ALU_0, iq_is_ALU_1, iq_is_load_0, iq_is_load_1;
  logic             iq_is_branch_0, iq_serial_0, iq_serial_1;
  logic             ex_allowin, pipe_empty;
  logic             issue_valid0, issue_valid1;
  logic [1:0]       issue_num;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 aclk = ~aclk;

  issue_ctrl #(.LOAD_LAT(2), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset), .flush(flush), .iq_valid(iq_valid),
    .iq_rd0(iq_rd0), .iq_rj0(iq_rj0), .iq_rk0(iq_rk0),
    .iq_rd1(iq_rd1), .iq_rj1(iq_rj1), .iq_rk1(iq_rk1),
    .iq_is_ALU_0(iq_is_ALU_0), .iq_is_ALU_1(iq_is_ALU_1),
    .iq_is_load_0(iq_is_load_0), .iq_is_load_1(iq_is_load_1),
    .iq_is_branch_0(iq_is_branch_0), .iq_serial_0(iq_serial_0), .iq_serial_1(iq_serial_1),
    .ex_allowin(ex_allowin), .pipe_empty(pipe_empty),
    .issue_valid0(issue_valid0), .issue_valid1(issue_valid1),
    .issue_num(issue_num), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic v0, input logic v1, input logic [1:0] n);
    #1;
    chk({tag, "_v0"}, 32'(issue_valid0), 32'(v0));
    chk({tag, "_v1"}, 32'(issue_valid1), 32'(v1));
    chk({tag, "_num"}, 32'(issue_num), 32'(n));
  endtask

  task automatic chk_state(input string tag, input issue_state_e s);
    chk(tag, 32'(dut.r_state), 32'(s));
  endtask

  task automatic idle();
    iq_valid = 2'b00;
    iq_rd0 = 0; iq_rj0 = 0; iq_rk0 = 0; iq_rd1 = 0; iq_rj1 = 0; iq_rk1 = 0;
    iq_is_ALU_0 = 0; iq_is_ALU_1 = 0; iq_is_load_0 = 0; iq_is_load_1 = 0;
    iq_is_branch_0 = 0; iq_serial_0 = 0; iq_serial_1 = 0;
  endtask

  task automatic put0(input logic [4:0] d, input logic [4:0] j, input logic [4:0] k,
                      input logic alu, input logic ld);
    iq_valid[0] = 1'b1; iq_rd0 = d; iq_rj0 = j; iq_rk0 = k;
    iq_is_ALU_0 = alu; iq_is_load_0 = ld; iq_is_branch_0 = 1'b0; iq_serial_0 = 1'b0;
  endtask

  task automatic put1(input logic [4:0] d, input logic [4:0] j, input logic [4:0] k,
                      input logic alu, input logic ld);
    iq_valid[1] = 1'b1; iq_rd1 = d; iq_rj1 = j; iq_rk1 = k;
    iq_is_ALU_1 = alu; iq_is_load_1 = ld; iq_serial_1 = 1'b0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    idle();
    areset = 1'b1; flush = 1'b0; ex_allowin = 1'b1; pipe_empty = 1'b0;
    put0(3, 1, 2, 1, 0); put1(6, 4, 0, 1, 0);
    repeat (2) @(posedge aclk);
    #1;
    chk_issue("rst", 0, 0, 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk_state("rst_state", ISSUE_RUN);
    areset = 1'b0;

    // independent ALU pair
    for (int i = 0; i < 3; i++) begin
      chk_issue("pair", 1, 1, 2); tick();
    end

    // intra-pair RAW on rj then the consumer at the head
    put0(5, 1, 2, 1, 0); put1(8, 5, 0, 1, 0); chk_issue("raw", 1, 0, 1); tick();
    put0(8, 5, 0, 1, 0); put1(9, 4, 0, 1, 0); chk_issue("raw_next", 1, 1, 2); tick();
    put0(5, 1, 2, 1, 0); put1(8, 0, 5, 1, 0); chk_issue("raw_rk", 1, 0, 1); tick();
    put0(7, 1, 2, 1, 0); put1(7, 3, 4, 1, 0); chk_issue("waw", 1, 0, 1); tick();
    put0(0, 1, 2, 1, 0); put1(0, 0, 0, 1, 0); chk_issue("r0_nodep", 1, 1, 2); tick();
    put0(3, 1, 2, 0, 0); put1(6, 4, 0, 0, 0); chk_issue("no_alu", 1, 0, 1); tick();
    put0(20, 1, 0, 0, 1); put1(21, 2, 0, 1, 1); chk_issue("two_ld", 1, 0, 1); tick();
    put0(0, 1, 2, 1, 0); iq_is_branch_0 = 1'b1; put1(6, 4, 0, 1, 0);
    chk_issue("br0", 1, 0, 1); tick();
    put0(3, 1, 2, 1, 0); put1(6, 4, 0, 1, 0); iq_serial_1 = 1'b1;
    chk_issue("ser1", 1, 0, 1); tick();
    chk_state("ser1_state", ISSUE_RUN);

    // slot 1 blocked by a pending load from the previous cycle
    idle(); put0(9, 1, 0, 0, 1); chk_issue("ld9", 1, 0, 1); tick();
    put0(10, 1, 0, 1, 0); put1(11, 9, 0, 1, 0); chk_issue("sb_s1", 1, 0, 1); tick();
    idle(); tick(); tick();

    // load issued from slot 1 enters the scoreboard
    put0(3, 1, 2, 1, 0); put1(15, 4, 0, 0, 1); chk_issue("ld_s1", 1, 1, 2); tick();
    idle(); put0(16, 15, 0, 1, 0); chk_issue("use_s1", 0, 0, 0); exp_stall++; tick();
    idle(); tick(); tick();

    // load-use spacing with LOAD_LAT=2
    put0(7, 1, 0, 0, 1); chk_issue("ld7", 1, 0, 1); tick();
    put0(8, 7, 0, 1, 0); chk_issue("use7_c1", 0, 0, 0); exp_stall++; tick();
    chk_issue("use7_c2", 0, 0, 0); exp_stall++; tick();
    chk_issue("use7_c3", 1, 0, 1);
    chk("stall_lu", 32'(stall_cycles), 32'(exp_stall)); tick();

    // flush clears the scoreboard and suppresses the stall count
    idle(); put0(13, 1, 0, 0, 1); chk_issue("ld13", 1, 0, 1); tick();
    put0(8, 13, 0, 1, 0); flush = 1'b1; chk_issue("flush_sb", 0, 0, 0); tick();
    flush = 1'b0; chk_issue("post_flush", 1, 0, 1);
    chk("stall_flush", 32'(stall_cycles), 32'(exp_stall)); tick();

    // backpressure freezes the scoreboard
    idle(); put0(14, 1, 0, 0, 1); chk_issue("ld14", 1, 0, 1); tick();
    put0(8, 0, 14, 1, 0); ex_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_issue("bp_hold", 0, 0, 0); tick();
    end
    ex_allowin = 1'b1;
    chk_issue("bp_c1", 0, 0, 0); exp_stall++; tick();
    chk_issue("bp_c2", 0, 0, 0); exp_stall++; tick();
    chk_issue("bp_c3", 1, 0, 1);
    chk("stall_bp", 32'(stall_cycles), 32'(exp_stall)); tick();

    // serialisation: RUN -> DRAIN -> SOLO -> POST -> RUN
    idle(); put0(0, 0, 0, 0, 0); iq_serial_0 = 1'b1; put1(6, 4, 0, 1, 0); pipe_empty = 1'b0;
    chk_issue("ser_run", 0, 0, 0); exp_stall++; tick();
    chk_issue("drain1", 0, 0, 0); exp_stall++; tick();
    chk_issue("drain2", 0, 0, 0); exp_stall++; chk_state("st_drain", ISSUE_DRAIN); tick();
    pipe_empty = 1'b1; chk_issue("drain_pe", 0, 0, 0); exp_stall++; tick();
    pipe_empty = 1'b0; chk_state("st_solo", ISSUE_SOLO); chk_issue("solo", 1, 0, 1); tick();
    idle(); put0(3, 1, 2, 1, 0); put1(6, 4, 0, 1, 0);
    chk_issue("post1", 0, 0, 0); exp_stall++; chk_state("st_post", ISSUE_POST); tick();
    chk_issue("post2", 0, 0, 0); exp_stall++; tick();
    pipe_empty = 1'b1; chk_issue("post_pe", 0, 0, 0); exp_stall++; tick();
    chk_issue("resume", 1, 1, 2);
    chk("stall_ser", 32'(stall_cycles), 32'(exp_stall)); tick();

    // flush while draining
    pipe_empty = 1'b0;
    idle(); put0(0, 0, 0, 0, 0); iq_serial_0 = 1'b1; put1(6, 4, 0, 1, 0);
    chk_issue("ser_run2", 0, 0, 0); exp_stall++; tick();
    chk_state("st_drain2", ISSUE_DRAIN); chk_issue("drain3", 0, 0, 0); exp_stall++; tick();
    flush = 1'b1; put0(3, 1, 2, 1, 0); put1(6, 4, 0, 1, 0);
    chk_issue("flush_drain", 0, 0, 0); tick();
    flush = 1'b0; chk_state("st_flush_run", ISSUE_RUN);
    chk_issue("flush_pair", 1, 1, 2);
    chk("stall_fd", 32'(stall_cycles), 32'(exp_stall)); tick();

    // saturation: 14 counted so far, 60 more blocked cycles exceed 63
    idle(); put0(0, 0, 0, 0, 0); iq_serial_0 = 1'b1;
    repeat (60) tick();
    #1 chk("stall_sat", 32'(stall_cycles), 63);
    chk_state("st_sat", ISSUE_DRAIN);

    // async reset mid-cycle with a pair ready
    flush = 1'b1; tick(); flush = 1'b0;
    put0(3, 1, 2, 1, 0); put1(6, 4, 0, 1, 0);
    chk_issue("pre_rst", 1, 1, 2);
    #1 areset = 1'b1;
    chk_issue("mid_rst", 0, 0, 0);
    chk("mid_rst_stall", 32'(stall_cycles), 0);
    #1 areset = 1'b0;
    chk_issue("after_rst", 1, 1, 2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
